// File: rtl/uart_start_detect.sv
// Purpose : UART RX start-bit qualifier: synchronise rx_i, sample on tick_i, confirm a start bit after
//           MIN_LOW low samples that follow IDLE_HIGH high samples, flag aborted low runs, lock until re-armed.
// Latency : rx_i edge -> sample after SYNC_STAGES clocks plus wait for next tick; start_o/false_start_o are
//           registered, 1 clk after the qualifying tick; armed_o/locked_o valid the cycle after a transition.
// Backpressure: none; the RX frame engine holds the detector in LOCKED until it pulses rearm_i.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   enable_i      detector enable; low holds the FSM in IDLE_WAIT (sync chain keeps running)
//   tick_i        oversample strobe, OVERSAMPLE per bit
//   rx_i          raw serial line, idle high, asynchronous
//   rearm_i       pulse from frame engine releasing LOCKED
//   start_o       pulse: start bit confirmed
//   false_start_o pulse: low run ended before MIN_LOW samples
//   armed_o       level: ARMED or QUALIFY
//   locked_o      level: LOCKED
//
// Build option: define UART_START_MAJORITY_EN to filter samples through a 2-of-3 majority vote
// (one extra tick of detection latency, single-tick glitches are absorbed).

`timescale 1ns/1ps

module uart_start_detect #(
    parameter int OVERSAMPLE  = 16,
    parameter int MIN_LOW     = 8,
    parameter int IDLE_HIGH   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic tick_i,
    input  logic rx_i,
    input  logic rearm_i,
    output logic start_o,
    output logic false_start_o,
    output logic armed_o,
    output logic locked_o
);

    localparam int CW = $clog2(OVERSAMPLE + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(OVERSAMPLE);
    localparam logic [CW-1:0] IDLE_TGT = CW'(IDLE_HIGH);
    localparam logic [CW-1:0] LOW_TGT  = CW'(MIN_LOW);

    typedef enum logic [1:0] {
        IDLE_WAIT = 2'd0,
        ARMED     = 2'd1,
        QUALIFY   = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser; resets to all ones so the line looks idle.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sample selection
    // ------------------------------------------------------------------
    logic s;

`ifdef UART_START_MAJORITY_EN
    // Three-sample window: the two previous tick samples held in hist_q plus
    // the sample taken on the current tick. The vote therefore trails the
    // line by one tick, and an isolated opposite sample is always outvoted.
    logic [1:0] hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= 2'b11;
        end else if (tick_i) begin
            hist_q <= {hist_q[0], sync_out};
        end
    end

    assign s = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync_out) | (hist_q[0] & sync_out);
`else
    assign s = sync_out;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            start_d, false_d, armed_d, locked_d;

    // Counter saturates rather than wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE_WAIT;
            cnt_q         <= '0;
            start_o       <= 1'b0;
            false_start_o <= 1'b0;
            armed_o       <= 1'b0;
            locked_o      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            start_o       <= start_d;
            false_start_o <= false_d;
            armed_o       <= armed_d;
            locked_o      <= locked_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        false_d = 1'b0;

        if (!enable_i) begin
            // Disable drops everything; qualification restarts from scratch.
            state_d = IDLE_WAIT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE_WAIT: begin
                    if (tick_i) begin
                        if (s) begin
                            if (cnt_inc >= IDLE_TGT) begin
                                state_d = ARMED;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                end
                ARMED: begin
                    if (tick_i && !s) begin
                        // The falling sample is the first low sample of the run.
                        if (LOW_TGT <= CW'(1)) begin
                            state_d = LOCKED;
                            cnt_d   = '0;
                            start_d = 1'b1;
                        end else begin
                            state_d = QUALIFY;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                QUALIFY: begin
                    if (tick_i) begin
                        if (!s) begin
                            if (cnt_inc >= LOW_TGT) begin
                                state_d = LOCKED;
                                cnt_d   = '0;
                                start_d = 1'b1;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end else begin
                            state_d = ARMED;
                            cnt_d   = '0;
                            false_d = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    // rx and tick are ignored; a tick coinciding with rearm is dropped.
                    if (rearm_i) begin
                        state_d = IDLE_WAIT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE_WAIT;
                    cnt_d   = '0;
                end
            endcase
        end

        armed_d  = (state_d == ARMED) || (state_d == QUALIFY);
        locked_d = (state_d == LOCKED);
    end

endmodule

// File: tb/tb_uart_start_detect.sv
// Purpose : directed, table-driven bench for uart_start_detect (default parameters plus a
//           MIN_LOW=1 / IDLE_HIGH=1 / OVERSAMPLE=4 instance).
// Latency : each step settles rx for 3 clocks, then applies one tick cycle and samples 1 ns later.
// Backpressure: not applicable.

`timescale 1ns/1ps

module tb_uart_start_detect;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_ni, enable_i, tick_i, rx_i, rearm_i, en2;
    logic start_o, false_start_o, armed_o, locked_o;
    logic start2, false2, armed2, locked2;

    uart_start_detect dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .tick_i(tick_i),
        .rx_i(rx_i), .rearm_i(rearm_i), .start_o(start_o), .false_start_o(false_start_o),
        .armed_o(armed_o), .locked_o(locked_o)
    );

    uart_start_detect #(.OVERSAMPLE(4), .MIN_LOW(1), .IDLE_HIGH(1), .SYNC_STAGES(2)) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(en2), .tick_i(tick_i),
        .rx_i(rx_i), .rearm_i(rearm_i), .start_o(start2), .false_start_o(false2),
        .armed_o(armed2), .locked_o(locked2)
    );

    int checks = 0;
    int failures = 0;
    int n_start = 0, n_false = 0, n_overlap = 0, n_start2 = 0;
    int exp_start_tot = 0, exp_false_tot = 0;

    // Pulse counters catch pulses that fall between sample points.
    always @(posedge clk_i) begin
        if (start_o) n_start++;
        if (false_start_o) n_false++;
        if (start_o && false_start_o) n_overlap++;
        if (start2) n_start2++;
    end

    typedef struct {
        logic       en;
        logic       rx;
        logic       tk;
        logic       rr;
        logic [3:0] exp; // {start, false_start, armed, locked}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic a_en, input logic a_rx, input logic a_tk,
                       input logic a_rr, input logic [3:0] a_exp);
        vec_t v;
        v.en = a_en; v.rx = a_rx; v.tk = a_tk; v.rr = a_rr; v.exp = a_exp;
        tbl.push_back(v);
    endtask

    task automatic addn(input int n, input logic a_en, input logic a_rx, input logic a_tk,
                        input logic a_rr, input logic [3:0] a_exp);
        for (int k = 0; k < n; k++) add(a_en, a_rx, a_tk, a_rr, a_exp);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {start,false,armed,locked}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic [3:0] exp);
        exp_start_tot += int'(exp[3]);
        exp_false_tot += int'(exp[2]);
        check(name, {start_o, false_start_o, armed_o, locked_o}, exp);
    endtask

    task automatic check_cnt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered just after a rising edge; leaves 1 ns after the tick edge.
    task automatic step(input logic s_en, input logic s_rx, input logic s_tk, input logic s_rr);
        enable_i = s_en;
        rx_i     = s_rx;
        repeat (3) @(posedge clk_i);
        #1;
        tick_i  = s_tk;
        rearm_i = s_rr;
        @(posedge clk_i);
        #1;
        tick_i  = 1'b0;
        rearm_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; enable_i = 1'b1; tick_i = 1'b0; rx_i = 1'b1; rearm_i = 1'b0; en2 = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check1("reset_state", 4'b0000);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

`ifndef UART_START_MAJORITY_EN
        // Clean start
        addn(3, 1, 1, 1, 0, 4'b0000);
        add (1, 1, 1, 0, 4'b0010);
        add (1, 0, 0, 0, 4'b0010);          // no tick: nothing advances
        addn(7, 1, 0, 1, 0, 4'b0010);
        add (1, 0, 1, 0, 4'b1001);          // 8th low tick
        addn(8, 1, 0, 1, 0, 4'b0001);
        add (1, 1, 1, 0, 4'b0001);          // LOCKED ignores the line
        // Re-arm collides with tick while rx low
        add (1, 0, 1, 1, 4'b0000);
        add (1, 0, 1, 0, 4'b0000);
        addn(3, 1, 1, 1, 0, 4'b0000);
        add (1, 1, 1, 0, 4'b0010);
        add (1, 1, 0, 1, 4'b0010);          // rearm outside LOCKED ignored
        // Glitches
        addn(3, 1, 0, 1, 0, 4'b0010);
        add (1, 1, 1, 0, 4'b0110);
        add (1, 1, 1, 0, 4'b0010);
        add (1, 0, 1, 0, 4'b0010);
        add (1, 1, 1, 0, 4'b0110);
        // Disable at 5th low tick, re-enable while low
        addn(4, 1, 0, 1, 0, 4'b0010);
        add (0, 0, 1, 0, 4'b0000);
        add (0, 0, 1, 0, 4'b0000);
        addn(3, 1, 0, 1, 0, 4'b0000);
        addn(3, 1, 1, 1, 0, 4'b0000);
        add (1, 1, 1, 0, 4'b0010);
        addn(7, 1, 0, 1, 0, 4'b0010);
        add (1, 0, 1, 0, 4'b1001);
        add (1, 0, 1, 1, 4'b0000);
`else
        addn(3, 1, 1, 1, 0, 4'b0000);
        add (1, 1, 1, 0, 4'b0010);
        add (1, 0, 1, 0, 4'b0010);          // single low tick absorbed
        addn(3, 1, 1, 1, 0, 4'b0010);
        addn(3, 1, 0, 1, 0, 4'b0010);       // 3-tick low run
        add (1, 1, 1, 0, 4'b0010);          // vote still low
        add (1, 1, 1, 0, 4'b0110);
        add (1, 1, 1, 0, 4'b0010);
        addn(8, 1, 0, 1, 0, 4'b0010);
        add (1, 0, 1, 0, 4'b1001);          // 9th low tick
        add (1, 0, 1, 0, 4'b0001);
        add (1, 0, 1, 1, 4'b0000);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].rx, tbl[i].tk, tbl[i].rr);
            check1($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Reset in the middle of a low run
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        check1("pre_reset_armed", 4'b0010);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check1("reset_immediate", 4'b0000);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0);
            check1($sformatf("post_reset_idle%0d", i), 4'b0000);
        end
        step(1, 1, 1, 0);
        check1("post_reset_armed", 4'b0010);

        // Minimal parameter instance; main instance held disabled
        en2 = 1'b1;
        step(0, 1, 1, 0);
        check("p1_armed", {start2, false2, armed2, locked2}, 4'b0010);
`ifdef UART_START_MAJORITY_EN
        step(0, 0, 1, 0);
        check("p1_vote", {start2, false2, armed2, locked2}, 4'b0010);
`endif
        step(0, 0, 1, 0);
        check("p1_start", {start2, false2, armed2, locked2}, 4'b1001);
        step(0, 0, 1, 0);
        check("p1_locked", {start2, false2, armed2, locked2}, 4'b0001);

        check_cnt("start_pulses", n_start, exp_start_tot);
        check_cnt("false_pulses", n_false, exp_false_tot);
        check_cnt("pulse_overlap", n_overlap, 0);
        check_cnt("p1_start_pulses", n_start2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
